// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, control-pattern, flag-class and FSM state definitions for
// the ALU0 op sequencer and its opcode ROM. Optional macro: ALU_BACK2BACK_EN.
package alu_ctrl_pkg;

    localparam int OPW   = 4;
    localparam int CTRLW = 6;

    localparam logic [1:0] FLAG_RST = 2'b00;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_OR  = 4'd2,
        OP_NOT = 4'd3,
        OP_XOR = 4'd4,
        OP_AND = 4'd5,
        OP_MOV = 4'd6,
        OP_INC = 4'd7,
        OP_DEC = 4'd8,
        OP_SLA = 4'd9,
        OP_SLL = 4'd10,
        OP_ROL = 4'd11,
        OP_SRA = 4'd12,
        OP_SRL = 4'd13,
        OP_ROR = 4'd14,
        OP_ILL = 4'd15
    } op_e;

    // Bit i of each pattern is Ctrl<i>, so these read as the Ctrl0..Ctrl5
    // string reversed.
    localparam logic [CTRLW-1:0] CTRL_ADD = 6'b010010;
    localparam logic [CTRLW-1:0] CTRL_SUB = 6'b100010;
    localparam logic [CTRLW-1:0] CTRL_OR  = 6'b010100;
    localparam logic [CTRLW-1:0] CTRL_NOT = 6'b001100;
    localparam logic [CTRLW-1:0] CTRL_XOR = 6'b011100;
    localparam logic [CTRLW-1:0] CTRL_AND = 6'b011000;
    localparam logic [CTRLW-1:0] CTRL_MOV = 6'b000000;
    localparam logic [CTRLW-1:0] CTRL_INC = 6'b110110;
    localparam logic [CTRLW-1:0] CTRL_DEC = 6'b000110;
    localparam logic [CTRLW-1:0] CTRL_SLA = 6'b001001;
    localparam logic [CTRLW-1:0] CTRL_SLL = 6'b000001;
    localparam logic [CTRLW-1:0] CTRL_ROL = 6'b010001;
    localparam logic [CTRLW-1:0] CTRL_SRA = 6'b001101;
    localparam logic [CTRLW-1:0] CTRL_SRL = 6'b000101;
    localparam logic [CTRLW-1:0] CTRL_ROR = 6'b010101;

    typedef enum logic [1:0] {
        FC_NONE  = 2'd0,
        FC_LOGIC = 2'd1,
        FC_ARITH = 2'd2
    } flag_class_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_rom.sv
// Combinational opcode decode: op_code -> {ctrl, flag_class, illegal}.
// Ports: op_code in; ctrl, flag_class, illegal out.
module alu_op_rom
    import alu_ctrl_pkg::*;
(
    input  logic [OPW-1:0]   op_code,
    output logic [CTRLW-1:0] ctrl,
    output flag_class_e      flag_class,
    output logic             illegal
);

    always_comb begin
        ctrl       = CTRL_MOV;
        flag_class = FC_NONE;
        illegal    = 1'b0;
        case (op_code)
            OP_ADD: begin ctrl = CTRL_ADD; flag_class = FC_ARITH; end
            OP_SUB: begin ctrl = CTRL_SUB; flag_class = FC_ARITH; end
            OP_OR:  begin ctrl = CTRL_OR;  flag_class = FC_LOGIC; end
            OP_NOT: begin ctrl = CTRL_NOT; flag_class = FC_LOGIC; end
            OP_XOR: begin ctrl = CTRL_XOR; flag_class = FC_LOGIC; end
            OP_AND: begin ctrl = CTRL_AND; flag_class = FC_LOGIC; end
            OP_MOV: begin ctrl = CTRL_MOV; flag_class = FC_NONE;  end
            OP_INC: begin ctrl = CTRL_INC; flag_class = FC_ARITH; end
            OP_DEC: begin ctrl = CTRL_DEC; flag_class = FC_ARITH; end
            OP_SLA: begin ctrl = CTRL_SLA; flag_class = FC_ARITH; end
            OP_SLL: begin ctrl = CTRL_SLL; flag_class = FC_ARITH; end
            OP_ROL: begin ctrl = CTRL_ROL; flag_class = FC_ARITH; end
            OP_SRA: begin ctrl = CTRL_SRA; flag_class = FC_ARITH; end
            OP_SRL: begin ctrl = CTRL_SRL; flag_class = FC_ARITH; end
            OP_ROR: begin ctrl = CTRL_ROR; flag_class = FC_ARITH; end
            default: begin
                // Illegal opcode behaves as MOV and never touches flags.
                ctrl       = CTRL_MOV;
                flag_class = FC_NONE;
                illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU0 op sequencer: accepts an opcode over valid/ready, drives Ctrl0..Ctrl5
// for one EXEC cycle, owns carry/zero flags, pulses done (and illegal) in WB.
// Ports: clk, rst_n (sync, active-low); op_valid/op_ready/op_code/op_setf;
// alu_ctrl/alu_ctrl_valid; c_flag/z_flag; alu_c_in/alu_z_in; done/illegal.
// Optional macro ALU_BACK2BACK_EN: also accept in WB (1 op / 2 cycles).
module alu_op_sequencer
    import alu_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [OPW-1:0]   op_code,
    input  logic             op_setf,
    output logic [CTRLW-1:0] alu_ctrl,
    output logic             alu_ctrl_valid,
    output logic             c_flag,
    output logic             z_flag,
    input  logic             alu_c_in,
    input  logic             alu_z_in,
    output logic             done,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [OPW-1:0]   op_q;
    logic             setf_q;
    logic             c_q, z_q;
    logic [CTRLW-1:0] rom_ctrl;
    flag_class_e      rom_fc;
    logic             rom_ill;
    logic             accept;

    alu_op_rom u_rom (
        .op_code    (op_q),
        .ctrl       (rom_ctrl),
        .flag_class (rom_fc),
        .illegal    (rom_ill)
    );

    always_comb begin
        op_ready = 1'b0;
        case (state_q)
            S_IDLE: op_ready = 1'b1;
`ifdef ALU_BACK2BACK_EN
            S_WB:   op_ready = 1'b1;
`endif
            default: op_ready = 1'b0;
        endcase
    end

    assign accept = op_valid & op_ready;

    always_comb begin
        state_d        = state_q;
        alu_ctrl       = '0;
        alu_ctrl_valid = 1'b0;
        done           = 1'b0;
        illegal        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_ctrl       = rom_ctrl;
                alu_ctrl_valid = 1'b1;
                state_d        = S_WB;
            end
            S_WB: begin
                done    = 1'b1;
                illegal = rom_ill;
                state_d = accept ? S_EXEC : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            setf_q     <= 1'b0;
            {z_q, c_q} <= FLAG_RST;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_code;
                setf_q <= op_setf;
            end
            // Flags commit on the EXEC->WB edge so a back-to-back op's
            // EXEC already sees the updated carry.
            if (state_q == S_EXEC && setf_q) begin
                case (rom_fc)
                    FC_ARITH: begin
                        c_q <= alu_c_in;
                        z_q <= alu_z_in;
                    end
                    FC_LOGIC: begin
                        c_q <= 1'b0;
                        z_q <= alu_z_in;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign c_flag = c_q;
    assign z_flag = z_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed, table-driven self-checking bench for alu_op_sequencer.
// Honours ALU_BACK2BACK_EN for the throughput check.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_code;
    logic       op_setf;
    logic [5:0] alu_ctrl;
    logic       alu_ctrl_valid;
    logic       c_flag, z_flag;
    logic       alu_c_in, alu_z_in;
    logic       done, illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_code        (op_code),
        .op_setf        (op_setf),
        .alu_ctrl       (alu_ctrl),
        .alu_ctrl_valid (alu_ctrl_valid),
        .c_flag         (c_flag),
        .z_flag         (z_flag),
        .alu_c_in       (alu_c_in),
        .alu_z_in       (alu_z_in),
        .done           (done),
        .illegal        (illegal)
    );

    typedef struct {
        logic [3:0] op;
        logic       setf;
        logic       c_in;
        logic       z_in;
        logic [5:0] ctrl;
        logic       c_exp;
        logic       z_exp;
        logic       ill_exp;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE and walk it through EXEC and WB.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic setf, input logic cin,
                          input logic zin, input logic [5:0] ctrl,
                          input logic ce, input logic ze, input logic ie);
        chk({name, " ready"}, op_ready, 1);
        op_valid = 1'b1;
        op_code  = op;
        op_setf  = setf;
        tick();
        op_valid = 1'b0;
        alu_c_in = cin;
        alu_z_in = zin;
        chk({name, " ctrl"}, alu_ctrl, ctrl);
        chk({name, " cvalid"}, alu_ctrl_valid, 1);
        tick();
        alu_c_in = 1'b0;
        alu_z_in = 1'b0;
        chk({name, " done"}, done, 1);
        chk({name, " illegal"}, illegal, ie);
        chk({name, " wbctrl"}, {alu_ctrl_valid, alu_ctrl}, 0);
        chk({name, " c"}, c_flag, ce);
        chk({name, " z"}, z_flag, ze);
        tick();
        chk({name, " idle done"}, done, 0);
    endtask

    initial begin
        int hs [$];
        int gap;

        // Sweep: setf=1, c_in=1, z_in=odd(op); flags carried op to op.
        vecs[0]  = '{4'd0,  1, 1, 0, 6'b010010, 1, 0, 0};
        vecs[1]  = '{4'd1,  1, 1, 1, 6'b100010, 1, 1, 0};
        vecs[2]  = '{4'd2,  1, 1, 0, 6'b010100, 0, 0, 0};
        vecs[3]  = '{4'd3,  1, 1, 1, 6'b001100, 0, 1, 0};
        vecs[4]  = '{4'd4,  1, 1, 0, 6'b011100, 0, 0, 0};
        vecs[5]  = '{4'd5,  1, 1, 1, 6'b011000, 0, 1, 0};
        vecs[6]  = '{4'd6,  1, 1, 0, 6'b000000, 0, 1, 0};
        vecs[7]  = '{4'd7,  1, 1, 1, 6'b110110, 1, 1, 0};
        vecs[8]  = '{4'd8,  1, 1, 0, 6'b000110, 1, 0, 0};
        vecs[9]  = '{4'd9,  1, 1, 1, 6'b001001, 1, 1, 0};
        vecs[10] = '{4'd10, 1, 1, 0, 6'b000001, 1, 0, 0};
        vecs[11] = '{4'd11, 1, 1, 1, 6'b010001, 1, 1, 0};
        vecs[12] = '{4'd12, 1, 1, 0, 6'b001101, 1, 0, 0};
        vecs[13] = '{4'd13, 1, 1, 1, 6'b000101, 1, 1, 0};
        vecs[14] = '{4'd14, 1, 1, 0, 6'b010101, 1, 0, 0};
        vecs[15] = '{4'd15, 1, 1, 1, 6'b000000, 1, 0, 1};

        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_code  = '0;
        op_setf  = 1'b0;
        alu_c_in = 1'b0;
        alu_z_in = 1'b0;
        tick();
        tick();
        chk("rst ready", op_ready, 1);
        chk("rst ctrl", {alu_ctrl_valid, alu_ctrl}, 0);
        chk("rst flags", {z_flag, c_flag}, 0);
        chk("rst done", {done, illegal}, 0);
        rst_n = 1'b1;
        tick();

        // ADD sets carry, then AND sees it in EXEC and clears it.
        run_op("add", 4'd0, 1, 1, 0, 6'b010010, 1, 0, 0);
        chk("and ready", op_ready, 1);
        op_valid = 1'b1;
        op_code  = 4'd5;
        op_setf  = 1'b1;
        tick();
        op_valid = 1'b0;
        alu_c_in = 1'b1;
        alu_z_in = 1'b1;
        chk("and ctrl", alu_ctrl, 6'b011000);
        chk("and exec c", c_flag, 1);
        tick();
        alu_c_in = 1'b0;
        alu_z_in = 1'b0;
        chk("and done", done, 1);
        chk("and flags", {z_flag, c_flag}, 2'b10);
        tick();

        // MOV and illegal leave flags alone even with setf.
        run_op("mov", 4'd6, 1, 1, 0, 6'b000000, 0, 1, 0);
        run_op("ill", 4'd15, 1, 1, 0, 6'b000000, 0, 1, 1);

        // Held op_valid: spacing between accepted handshakes.
        op_valid = 1'b1;
        op_code  = 4'd0;
        op_setf  = 1'b0;
        alu_c_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (op_valid && op_ready) hs.push_back(i);
        end
        op_valid = 1'b0;
        alu_c_in = 1'b0;
        repeat (4) tick();
        if (hs.size() < 2) begin
            checks++;
            errors++;
            $display("FAIL hold hs: got %0d handshakes expected >=2",
                     hs.size());
        end else begin
            gap = hs[1] - hs[0];
`ifdef ALU_BACK2BACK_EN
            chk("hold gap", gap, 2);
`else
            chk("hold gap", gap, 3);
`endif
        end
        chk("hold flags", {z_flag, c_flag}, 2'b10);

        // Reset during EXEC of SUB drops the op and restores flags.
        op_valid = 1'b1;
        op_code  = 4'd1;
        op_setf  = 1'b1;
        tick();
        op_valid = 1'b0;
        alu_c_in = 1'b1;
        alu_z_in = 1'b1;
        chk("sub exec", alu_ctrl_valid, 1);
        rst_n = 1'b0;
        tick();
        alu_c_in = 1'b0;
        alu_z_in = 1'b0;
        chk("rst exec cvalid", alu_ctrl_valid, 0);
        chk("rst exec done", done, 0);
        chk("rst exec flags", {z_flag, c_flag}, 0);
        chk("rst exec ready", op_ready, 1);
        rst_n = 1'b1;
        tick();
        chk("rst exec nodone", done, 0);

        // Full opcode sweep.
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("op%0d", i), vecs[i].op, vecs[i].setf,
                   vecs[i].c_in, vecs[i].z_in, vecs[i].ctrl,
                   vecs[i].c_exp, vecs[i].z_exp, vecs[i].ill_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
